// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the memory command port and the arbiter.
// Handshake: a requester holds req (and its address/data) until it sees gnt in the same cycle, and that
// cycle is the transfer. A read grant returns rvalid plus rdata exactly one cycle later, and rvalid has no back-pressure.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_r_en;
  logic [ADDR_W-1:0] mem_r_addr;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [DATA_W-1:0] mem_w_data;
  logic [DATA_W-1:0] mem_r_data;

  logic [15:0]       stat_conflicts;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_r_data,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_r_en, mem_r_addr, mem_w_en, mem_w_addr, mem_w_data, stat_conflicts
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_r_data,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_r_en, mem_r_addr, mem_w_en, mem_w_addr, mem_w_data, stat_conflicts
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto a single-port memory with 1-cycle read latency.
// The grant is combinational. Read responses are routed back to their owner by a registered flag.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_arbiter_if.slave     bus,
  output logic             dbg_last_gnt
);

  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_e;

  gnt_e              last_gnt_q, last_gnt_d;
  logic              i_win, d_win, contention;
  logic              own_i_q, own_d_q;
  logic [15:0]       conflicts_q;
  logic              r_en, w_en;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] w_data;

  // Grants are suppressed while reset is asserted so no memory command leaks out.
  always_comb begin
    i_win      = 1'b0;
    d_win      = 1'b0;
    last_gnt_d = last_gnt_q;
    contention = bus.i_req && bus.d_req;
    if (rst_n) begin
      if (contention) begin
        if (FIXED_PRIO || last_gnt_q == GNT_I) d_win = 1'b1;
        else                                   i_win = 1'b1;
      end else begin
        i_win = bus.i_req;
        d_win = bus.d_req;
      end
    end
    if (i_win)      last_gnt_d = GNT_I;
    else if (d_win) last_gnt_d = GNT_D;
  end

  always_comb begin
    r_en   = 1'b0;
    r_addr = '0;
    w_en   = 1'b0;
    w_addr = '0;
    w_data = '0;
    if (i_win) begin
      r_en   = 1'b1;
      r_addr = bus.i_addr;
    end else if (d_win && !bus.d_we) begin
      r_en   = 1'b1;
      r_addr = bus.d_addr;
    end else if (d_win) begin
      w_en   = 1'b1;
      w_addr = bus.d_addr;
      w_data = bus.d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q  <= GNT_D;
      own_i_q     <= 1'b0;
      own_d_q     <= 1'b0;
      conflicts_q <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      own_i_q    <= i_win;
      own_d_q    <= d_win && !bus.d_we;
      if (contention && conflicts_q != 16'hFFFF) conflicts_q <= conflicts_q + 16'd1;
    end
  end

  assign bus.i_gnt          = i_win;
  assign bus.d_gnt          = d_win;
  assign bus.mem_r_en       = r_en;
  assign bus.mem_r_addr     = r_addr;
  assign bus.mem_w_en       = w_en;
  assign bus.mem_w_addr     = w_addr;
  assign bus.mem_w_data     = w_data;
  assign bus.i_rvalid       = own_i_q;
  assign bus.d_rvalid       = own_d_q;
  assign bus.i_rdata        = bus.mem_r_data;
  assign bus.d_rdata        = bus.mem_r_data;
  assign bus.stat_conflicts = conflicts_q;
  assign dbg_last_gnt       = (last_gnt_q == GNT_D);

endmodule
